// File: rtl/auth_session_ctrl_pkg.sv
// Shared definitions for the session controller: state encoding and watchdog length.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package auth_session_ctrl_pkg;

    // Session FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_LOGOUT = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    // If the authenticator has not dropped LogIn this many cycles after
    // GCLogOut was raised, give up waiting and return to idle.
    localparam int unsigned LOGOUT_WDOG_CYCLES = 16;

endpackage

// File: rtl/auth_session_ctrl_timer.sv
// Shared cycle timer: counts up while enabled, clears on request, flags a terminal value.
// Latency: count updates one cycle after clr/en; at_term is combinational on the count.
// Backpressure: none; the timer always accepts its controls.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : force count to zero (wins over en)
//   en        : increment count this cycle
//   sat       : 1 = hold at all-ones instead of wrapping
//   term      : terminal value to compare against
//   at_term   : count == term
module session_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sat,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(sat && (count == '1))) begin
            count <= count + ONE;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/auth_session_ctrl.sv
// Session scheduler around the authenticator: Enter gating, failed-attempt lockout, idle logout.
// Latency: Game_Enter_out is combinational (zero cycles); all other outputs are registered (1 cycle).
// Backpressure: none; single-cycle strobes in, strobes/levels out, nothing is queued.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   Game_Enter_in   : debounced Enter pulse from the board
//   Activity        : any user action reported by the game controller
//   Pass_Fail       : wrong-password pulse from the password controller
//   LogIn           : authenticator login status (level)
//   InternalID      : authenticator user index, valid while LogIn=1
//   Game_Enter_out  : Enter forwarded to the authenticator
//   GCLogOut        : logout request to the authenticator (level)
//   Locked          : lockout active
//   Session_ID      : ID latched at login, 0 with no session
//   Fail_Count      : consecutive failed attempts
module auth_session_ctrl
    import auth_session_ctrl_pkg::*;
#(
    parameter int IDLE_TIMEOUT   = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 500,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Game_Enter_in,
    input  logic       Activity,
    input  logic       Pass_Fail,
    input  logic       LogIn,
    input  logic [4:0] InternalID,
    output logic       Game_Enter_out,
    output logic       GCLogOut,
    output logic       Locked,
    output logic [4:0] Session_ID,
    output logic [2:0] Fail_Count
);

    localparam logic [CNT_W-1:0] T_IDLE = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_LOCK = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_WDOG = CNT_W'(LOGOUT_WDOG_CYCLES - 1);
    localparam logic [2:0]       MAX_FC = 3'(MAX_FAILS);

    state_t           state;
    logic             user_act;
    logic             tmr_clr;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_term;
    logic             tmr_at_term;
    logic [2:0]       fail_inc;

    // Enter counts as user activity for the idle timer.
    assign user_act = Activity | Game_Enter_in;

    // Enter is swallowed while locked, while a logout is pending, and in reset.
    assign Game_Enter_out = Game_Enter_in & ~Locked & ~GCLogOut & ~rst;

    // Saturating increment so the count can never pass the lockout threshold.
    assign fail_inc = (Fail_Count >= MAX_FC) ? MAX_FC : Fail_Count + 3'd1;

    // Timer control. The timer is cleared on every state change so each
    // state starts counting from zero; in idle it simply sits at zero.
    always_comb begin
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = T_IDLE;
        case (state)
            S_IDLE: begin
                tmr_clr = 1'b1;
            end
            S_ACTIVE: begin
                tmr_term = T_IDLE;
                tmr_en   = 1'b1;
                tmr_clr  = !LogIn || user_act || tmr_at_term;
            end
            S_LOGOUT: begin
                tmr_term = T_WDOG;
                tmr_en   = 1'b1;
                tmr_clr  = !LogIn || tmr_at_term;
            end
            S_LOCKED: begin
                tmr_term = T_LOCK;
                tmr_en   = 1'b1;
                tmr_clr  = LogIn || tmr_at_term;
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
    end

    session_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .sat     (1'b1),
        .term    (tmr_term),
        .at_term (tmr_at_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            Session_ID <= '0;
            Fail_Count <= '0;
            GCLogOut   <= 1'b0;
            Locked     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A login beats a simultaneous failure and clears the count.
                    if (LogIn) begin
                        Session_ID <= InternalID;
                        Fail_Count <= '0;
                        state      <= S_ACTIVE;
                    end else if (Pass_Fail) begin
                        Fail_Count <= fail_inc;
                        if (fail_inc == MAX_FC) begin
                            Locked <= 1'b1;
                            state  <= S_LOCKED;
                        end
                    end
                end
                S_ACTIVE: begin
                    // User-initiated logout takes priority over the idle timeout.
                    if (!LogIn) begin
                        Session_ID <= '0;
                        state      <= S_IDLE;
                    end else if (!user_act && tmr_at_term) begin
                        GCLogOut <= 1'b1;
                        state    <= S_LOGOUT;
                    end
                end
                S_LOGOUT: begin
                    // Leave on LogIn drop, or after the watchdog if it never drops.
                    if (!LogIn || tmr_at_term) begin
                        GCLogOut   <= 1'b0;
                        Session_ID <= '0;
                        state      <= S_IDLE;
                    end
                end
                S_LOCKED: begin
                    // A login here means the authenticator ignored the lock;
                    // treat it as a real session so downstream sees the ID.
                    if (LogIn) begin
                        Locked     <= 1'b0;
                        Session_ID <= InternalID;
                        Fail_Count <= '0;
                        state      <= S_ACTIVE;
                    end else if (tmr_at_term) begin
                        Locked     <= 1'b0;
                        Fail_Count <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auth_session_ctrl.sv
module tb_auth_session_ctrl;

    localparam int IDLE_TO = 20;
    localparam int MAXF    = 3;
    localparam int LOCKC   = 10;
    localparam int WDOG    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ge  = 1'b0;
    logic       act = 1'b0;
    logic       pf  = 1'b0;
    logic       li  = 1'b0;
    logic [4:0] id  = 5'd0;
    logic       geo;
    logic       gcl;
    logic       lk;
    logic [4:0] sid;
    logic [2:0] fc;

    always #5 clk = ~clk;

    auth_session_ctrl #(
        .IDLE_TIMEOUT   (IDLE_TO),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LOCKC),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Game_Enter_in  (ge),
        .Activity       (act),
        .Pass_Fail      (pf),
        .LogIn          (li),
        .InternalID     (id),
        .Game_Enter_out (geo),
        .GCLogOut       (gcl),
        .Locked         (lk),
        .Session_ID     (sid),
        .Fail_Count     (fc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the session as a handful of counters: consecutive idle cycles in
    // a session, cycles left in a lockout, and age of a pending logout.
    int m_sess, m_fails, m_lock_left, m_idle_run, m_logout_age;
    bit m_in_sess, m_logout;

    task automatic model_reset();
        m_sess = 0; m_fails = 0; m_lock_left = 0; m_idle_run = 0;
        m_logout_age = 0; m_in_sess = 0; m_logout = 0;
    endtask

    task automatic model_step(input logic g, input logic a, input logic p,
                              input logic l, input logic [4:0] i);
        if (m_lock_left > 0) begin
            if (l) begin
                m_lock_left = 0; m_in_sess = 1; m_sess = int'(i);
                m_fails = 0; m_idle_run = 0;
            end else begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end
        end else if (m_logout) begin
            m_logout_age++;
            if (!l || m_logout_age == WDOG) begin
                m_logout = 0; m_sess = 0;
            end
        end else if (m_in_sess) begin
            if (!l) begin
                m_in_sess = 0; m_sess = 0;
            end else if (a || g) begin
                m_idle_run = 0;
            end else begin
                m_idle_run++;
                if (m_idle_run == IDLE_TO) begin
                    m_in_sess = 0; m_logout = 1; m_logout_age = 0;
                end
            end
        end else begin
            if (l) begin
                m_in_sess = 1; m_sess = int'(i); m_fails = 0; m_idle_run = 0;
            end else if (p) begin
                m_fails++;
                if (m_fails == MAXF) m_lock_left = LOCKC;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        ge = 0; act = 0; pf = 0; li = 0; id = 5'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(input logic g, input logic a, input logic p,
                         input logic l, input logic [4:0] i);
        @(negedge clk);
        ge = g; act = a; pf = p; li = l; id = i;
    endtask

    task automatic rcycle(input logic g, input logic a, input logic p,
                          input logic l, input logic [4:0] i);
        logic exp_geo;
        @(negedge clk);
        chk("rnd_gclogout", 32'(gcl), 32'(m_logout));
        chk("rnd_locked",   32'(lk),  32'(m_lock_left > 0));
        chk("rnd_sess_id",  32'(sid), 32'(m_sess));
        chk("rnd_fail_cnt", 32'(fc),  32'(m_fails));
        ge = g; act = a; pf = p; li = l; id = i;
        #1;
        exp_geo = g && !(m_lock_left > 0) && !m_logout;
        chk("rnd_enter_out", 32'(geo), 32'(exp_geo));
        @(posedge clk);
        model_step(g, a, p, l, i);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       g, a, p, l;
        logic [4:0] i;
        logic       x_geo, x_gcl, x_lk;
        logic [4:0] x_sid;
        logic [2:0] x_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic g, input logic a, input logic p, input logic l,
                                input logic [4:0] i, input logic xg, input logic xgc,
                                input logic xl, input logic [4:0] xs, input logic [2:0] xf);
        vec_t v;
        v.g = g; v.a = a; v.p = p; v.l = l; v.i = i;
        v.x_geo = xg; v.x_gcl = xgc; v.x_lk = xl; v.x_sid = xs; v.x_fc = xf;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int cnt;

        // -------- reset state, Enter suppressed while in reset --------
        ge = 1'b1;
        #2;
        chk("rst_enter_out", 32'(geo), 32'd0);
        chk("rst_gclogout",  32'(gcl), 32'd0);
        chk("rst_locked",    32'(lk),  32'd0);
        chk("rst_sess_id",   32'(sid), 32'd0);
        chk("rst_fail_cnt",  32'(fc),  32'd0);

        // -------- table: login latch, simultaneous events, lockout --------
        //               g  a  p  l  id     geo gcl lk sid   fc
        tbl.push_back(mk(0, 0, 0, 0, 5'd0,  0,  0,  0, 5'd0, 3'd0));
        tbl.push_back(mk(0, 0, 1, 0, 5'd0,  0,  0,  0, 5'd0, 3'd1));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0,  1,  0,  0, 5'd0, 3'd1));
        tbl.push_back(mk(0, 0, 1, 0, 5'd0,  0,  0,  0, 5'd0, 3'd2));
        tbl.push_back(mk(0, 0, 1, 1, 5'd9,  0,  0,  0, 5'd9, 3'd0));
        tbl.push_back(mk(1, 0, 0, 1, 5'd9,  1,  0,  0, 5'd9, 3'd0));
        tbl.push_back(mk(0, 0, 0, 0, 5'd0,  0,  0,  0, 5'd0, 3'd0));
        tbl.push_back(mk(0, 0, 1, 0, 5'd0,  0,  0,  0, 5'd0, 3'd1));
        tbl.push_back(mk(0, 0, 1, 0, 5'd0,  0,  0,  0, 5'd0, 3'd2));
        tbl.push_back(mk(0, 0, 1, 0, 5'd0,  0,  0,  1, 5'd0, 3'd3));
        for (int k = 0; k < LOCKC - 1; k++)
            tbl.push_back(mk((k % 2) == 0, 0, k == 1, 0, 5'd0, 0, 0, 1, 5'd0, 3'd3));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0,  0,  0,  0, 5'd0, 3'd0));
        tbl.push_back(mk(1, 0, 0, 0, 5'd0,  1,  0,  0, 5'd0, 3'd0));

        do_reset();
        foreach (tbl[n]) begin
            drive(tbl[n].g, tbl[n].a, tbl[n].p, tbl[n].l, tbl[n].i);
            #1;
            chk($sformatf("tbl%0d_enter_out", n), 32'(geo), 32'(tbl[n].x_geo));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_gclogout", n), 32'(gcl), 32'(tbl[n].x_gcl));
            chk($sformatf("tbl%0d_locked", n),   32'(lk),  32'(tbl[n].x_lk));
            chk($sformatf("tbl%0d_sess_id", n),  32'(sid), 32'(tbl[n].x_sid));
            chk($sformatf("tbl%0d_fail_cnt", n), 32'(fc),  32'(tbl[n].x_fc));
        end

        // -------- idle timeout without activity: 20 cycles --------
        do_reset();
        drive(0, 0, 0, 1, 5'd3);
        @(posedge clk);
        first = -1;
        for (int k = 1; k <= 60 && first < 0; k++) begin
            drive(0, 0, 0, 1, 5'd3);
            @(posedge clk);
            #1;
            if (gcl) first = k;
        end
        chk("timeout_cycles", 32'(first), 32'(IDLE_TO));
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, 5'd3);
            #1;
            chk("logout_enter_blocked", 32'(geo), 32'd0);
            @(posedge clk);
            #1;
            chk("logout_held", 32'(gcl), 32'd1);
        end
        drive(0, 0, 0, 0, 5'd0);
        @(posedge clk);
        #1;
        chk("logout_done_gcl", 32'(gcl), 32'd0);
        chk("logout_done_sid", 32'(sid), 32'd0);

        // -------- idle timeout with Activity at cycle 15 --------
        do_reset();
        drive(0, 0, 0, 1, 5'd4);
        @(posedge clk);
        first = -1;
        for (int k = 1; k <= 80 && first < 0; k++) begin
            drive(0, k == 15, 0, 1, 5'd4);
            @(posedge clk);
            #1;
            if (gcl) first = k;
        end
        chk("timeout_after_activity", 32'(first), 32'(15 + IDLE_TO));

        // -------- logout watchdog: LogIn never drops --------
        do_reset();
        drive(0, 0, 0, 1, 5'd7);
        @(posedge clk);
        first = -1;
        for (int k = 1; k <= 60 && first < 0; k++) begin
            drive(0, 0, 0, 1, 5'd7);
            @(posedge clk);
            #1;
            if (gcl) first = k;
        end
        chk("wdog_timeout_seen", 32'(first), 32'(IDLE_TO));
        first = -1;
        for (int k = 1; k <= 60 && first < 0; k++) begin
            drive(0, 0, 0, 1, 5'd7);
            @(posedge clk);
            #1;
            if (!gcl) first = k;
        end
        chk("wdog_cycles", 32'(first), 32'(WDOG));
        chk("wdog_sid",    32'(sid),   32'd0);
        chk("wdog_locked", 32'(lk),    32'd0);
        drive(0, 0, 0, 0, 5'd0);
        @(posedge clk);

        // -------- reset mid-session --------
        do_reset();
        drive(0, 0, 0, 1, 5'd9);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 1, 5'd9);
            @(posedge clk);
        end
        #1;
        chk("midsess_sid_before", 32'(sid), 32'd9);
        @(negedge clk);
        rst = 1'b1; ge = 1'b1;
        #1;
        chk("midsess_rst_sid", 32'(sid), 32'd0);
        chk("midsess_rst_gcl", 32'(gcl), 32'd0);
        chk("midsess_rst_geo", 32'(geo), 32'd0);
        @(negedge clk);
        ge = 1'b0; li = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            drive(0, 0, 0, 0, 5'd0);
            @(posedge clk);
            #1;
            if (gcl || sid != 5'd0) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);

        // -------- reset mid-lockout --------
        do_reset();
        for (int k = 0; k < MAXF; k++) begin
            drive(0, 0, 1, 0, 5'd0);
            @(posedge clk);
        end
        #1;
        chk("midlock_locked_before", 32'(lk), 32'd1);
        @(negedge clk);
        pf = 1'b0;
        rst = 1'b1;
        #1;
        chk("midlock_rst_locked", 32'(lk), 32'd0);
        chk("midlock_rst_fc",     32'(fc), 32'd0);

        // -------- randomized run against the model --------
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic       nl;
            logic [4:0] nid;
            nl  = li;
            nid = id;
            if (m_logout) begin
                if ($urandom_range(0, 9) == 0) nl = 1'b0;
            end else if (li) begin
                if ($urandom_range(0, 59) == 0) nl = 1'b0;
            end else if (m_lock_left > 0) begin
                if ($urandom_range(0, 199) == 0) begin nl = 1'b1; nid = 5'($urandom); end
            end else if ($urandom_range(0, 24) == 0) begin
                nl = 1'b1; nid = 5'($urandom);
            end
            rcycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 3) == 0, nl, nid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
